apb_completer_regs: RTL and testbench

APB3 completer (slave) holding a small memory-mapped register file, the counterpart of the bridge's APB master on the peripheral side. It answers transfers on one PSEL line (SLV1 window, base 0x0001_F000) with parameterised wait states and PSLVERR. It serves as the team's bring-up peripheral and the reference responder for bridge verification.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_regfile_core.sv | 39 +++
 rtl/apb_completer_regs.sv | 170 +++++++++++++++++
 tb/tb_apb_completer_regs.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM states, register offsets and
// the peripheral window bases used by both master and completers.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } apb_cmp_state_t;

    localparam logic [11:0] OFF_ID       = 12'h000;
    localparam logic [11:0] OFF_STATUS   = 12'h004;
    localparam logic [11:0] FIRST_RW_OFF = 12'h008;

    localparam logic [31:0] ID_DEFAULT = 32'hA2B0_0001;

    localparam logic [31:0] SLV1_BASE = 32'h0001_F000;
    localparam logic [31:0] SLV2_BASE = 32'h0002_0000;

endpackage

// File: rtl/apb_regfile_core.sv
// Register array for the APB completer: one synchronous write port
// and one combinational read port.
module apb_regfile_core #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int IW         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [IW-1:0]         widx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IW-1:0]         ridx_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            regs_d[widx_i] = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_o = regs_q[ridx_i];

endmodule

// File: rtl/apb_completer_regs.sv
// APB3 completer with ID, live STATUS and scratch registers,
// programmable wait states and PSLVERR on bad accesses.
module apb_completer_regs
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = SLV1_BASE,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = ID_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic [DATA_WIDTH-1:0] status_i
);

    localparam int IW = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] REG_SPAN = ADDR_WIDTH'(4 * NUM_REGS);
    localparam logic [IW-1:0] IDX_ID     = IW'(OFF_ID[11:2]);
    localparam logic [IW-1:0] IDX_STATUS = IW'(OFF_STATUS[11:2]);

    apb_cmp_state_t        state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;

    logic [ADDR_WIDTH-1:0] off;
    logic                  in_win;
    logic                  dec_err;
    logic                  go_resp;
    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rf_rdata;
    logic [DATA_WIDTH-1:0] rd_word;

    // Window check via the offset's upper bits: wraps below BASE_ADDR too.
    assign off    = paddr_i - BASE_ADDR;
    assign in_win = (off[ADDR_WIDTH-1:12] == '0);

    always_comb begin
        dec_err = !in_win
               || (off >= REG_SPAN)
               || (paddr_i[1:0] != 2'b00)
               || (pwrite_i && (off[11:0] < FIRST_RW_OFF));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        go_resp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (psel_i && !penable_i) begin
                    idx_d   = off[IW+1:2];
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    err_d   = dec_err;
                    cnt_d   = CW'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!psel_i) begin
                    state_d = ST_IDLE;
                end else if (penable_i) begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_word = rf_rdata;
        if (idx_d == IDX_ID) begin
            rd_word = ID_VALUE;
        end else if (idx_d == IDX_STATUS) begin
            rd_word = status_i;
        end
    end

    // Response is captured on the edge that enters RESP.
    always_comb begin
        pready_d  = go_resp;
        pslverr_d = go_resp && err_d;
        prdata_d  = '0;
        if (go_resp && !err_d && !write_d) begin
            prdata_d = rd_word;
        end
    end

    assign rf_we = (state_q == ST_RESP) && psel_i && penable_i
                && write_q && !err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    apb_regfile_core #(
        .NUM_REGS  (NUM_REGS),
        .DATA_WIDTH(DATA_WIDTH),
        .IW        (IW)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (rf_we),
        .widx_i (idx_q),
        .wdata_i(wdata_q),
        .ridx_i (idx_d),
        .rdata_o(rf_rdata)
    );

    assign prdata_o  = prdata_q;
    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: a zero-wait and a three-wait instance
// driven by directed and random transfers against an array model.
module tb_apb_completer_regs;

    localparam logic [31:0] BASE = 32'h0001_F000;
    localparam logic [31:0] ID   = 32'hA2B0_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel0 = 1'b0;
    logic        psel3 = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] status = '0;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3;
    logic        pslverr0, pslverr3;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem0 [16];
    logic [31:0] mem3 [16];

    always #5 clk = ~clk;

    apb_completer_regs #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .psel_i(psel0), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
        .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0),
        .status_i(status)
    );

    apb_completer_regs #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .psel_i(psel3), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
        .prdata_o(prdata3), .pready_o(pready3), .pslverr_o(pslverr3),
        .status_i(status)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic wr, input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        if (a < BASE || a > BASE + 32'hFFF) return 1'b1;
        if (a % 4 != 0) return 1'b1;
        if (o >= 64) return 1'b1;
        if (wr && o < 8) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_rd(input int d, input logic [31:0] a,
                                             input logic [31:0] st);
        logic [31:0] o;
        o = a - BASE;
        if (o == 0) return ID;
        if (o == 4) return st;
        return (d == 0) ? mem0[o/4] : mem3[o/4];
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? pready0 : pready3;
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? prdata0 : prdata3;
    endfunction

    function automatic logic serr(input int d);
        return (d == 0) ? pslverr0 : pslverr3;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            mem0[i] = '0;
            mem3[i] = '0;
        end
    endtask

    task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic err, output int lat);
        @(negedge clk);
        psel0 = (d == 0);
        psel3 = (d != 0);
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        lat = 1;
        while (!rdy(d) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rdat(d);
        err = serr(d);
        @(negedge clk);
        psel0 = 1'b0;
        psel3 = 1'b0;
        penable = 1'b0;
        chk("pready_one_cycle", 32'(rdy(d)), 32'd0);
        chk("prdata_cleared", rdat(d), 32'd0);
    endtask

    task automatic run(input string tag, input int d, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] st);
        logic [31:0] rd;
        logic        err;
        logic        e;
        int          lat;
        status = st;
        e = model_err(wr, a);
        xfer(d, wr, a, wd, rd, err, lat);
        chk({tag, "_lat"}, 32'(lat), (d == 0) ? 32'd1 : 32'd4);
        chk({tag, "_err"}, 32'(err), 32'(e));
        if (e || !wr) begin
            chk({tag, "_data"}, rd, e ? 32'd0 : model_rd(d, a, st));
        end
        if (wr && !e) begin
            if (d == 0) mem0[(a - BASE) / 4] = wd;
            else        mem3[(a - BASE) / 4] = wd;
        end
    endtask

    task automatic sweep(input string tag);
        for (int i = 2; i < 16; i++) begin
            run(tag, 0, 1'b0, BASE + 32'(4 * i), '0, '0);
            run(tag, 1, 1'b0, BASE + 32'(4 * i), '0, '0);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int          k;
        logic [31:0] far [3];
        far[0] = BASE - 32'd4;
        far[1] = BASE + 32'h1000;
        far[2] = 32'h0002_0008;
        k = $urandom_range(0, 4);
        if (k <= 2) return BASE + 32'(4 * $urandom_range(0, 17));
        if (k == 3) return BASE + 32'($urandom_range(0, 'h4F));
        return far[$urandom_range(0, 2)];
    endfunction

    initial begin
        clear_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pready0", 32'(pready0), 32'd0);
        chk("rst_pslverr0", 32'(pslverr0), 32'd0);
        chk("rst_prdata0", prdata0, 32'd0);
        chk("rst_pready3", 32'(pready3), 32'd0);
        chk("rst_prdata3", prdata3, 32'd0);

        run("id_read", 0, 1'b0, BASE, '0, 32'h1111_2222);
        run("wr_08", 0, 1'b1, BASE + 32'h8, 32'hDEAD_BEEF, '0);
        run("rd_08", 0, 1'b0, BASE + 32'h8, '0, '0);
        run("rd_0c", 0, 1'b0, BASE + 32'hC, '0, '0);
        run("status_ws3", 1, 1'b0, BASE + 32'h4, '0, 32'h0000_00A5);
        run("wr_id_err", 0, 1'b1, BASE, 32'h5A5A_5A5A, '0);
        run("wr_stat_err", 0, 1'b1, BASE + 32'h4, 32'h1, '0);
        run("wr_misalign", 0, 1'b1, BASE + 32'h2, 32'h2, '0);
        run("rd_oor", 0, 1'b0, BASE + 32'h40, '0, '0);
        run("id_again", 0, 1'b0, BASE, '0, '0);

        // Abort a WAIT-state write after one access cycle.
        @(negedge clk);
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = BASE + 32'h10; pwdata = 32'h1234;
        @(negedge clk);
        penable = 1'b1;
        chk("abort_wait_rdy", 32'(pready3), 32'd0);
        @(negedge clk);
        psel3 = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort_idle_rdy", 32'(pready3), 32'd0);
        run("abort_rb", 1, 1'b0, BASE + 32'h10, '0, '0);

        for (int n = 0; n < 80; n++) begin
            run("rand", $urandom_range(0, 1), 1'($urandom_range(0, 1)),
                rand_addr(), $urandom, $urandom);
        end

        // Reset during the WAIT of a write.
        @(negedge clk);
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = BASE + 32'h14; pwdata = 32'h5555_AAAA;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_wait_rdy", 32'(pready3), 32'd0);
        psel3 = 1'b0; penable = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        sweep("rst_wait_clr");

        // Reset while pready is high drops it asynchronously.
        run("pre_wr", 0, 1'b1, BASE + 32'h18, 32'hCAFE_F00D, '0);
        @(negedge clk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = BASE + 32'h1C; pwdata = 32'h7777_7777;
        @(negedge clk);
        penable = 1'b1;
        #1 chk("resp_rdy", 32'(pready0), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_resp_rdy", 32'(pready0), 32'd0);
        psel0 = 1'b0; penable = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        sweep("rst_resp_clr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
